register_readback: RTL

Read-side counterpart to the host's register write path. The host raises an asynchronous `read` strobe with an address. The block synchronises the strobe, detects its rising edge, and captures a snapshot of the addressed 8-bit register from a flattened register bank. It holds that snapshot stable on `read_register` with `read_valid` until the host releases the strobe. It sits between the host pin interface and the scope's control/status registers.

---
 rtl/register_readback.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/register_readback.sv
// Host register read-back: synchronises an asynchronous read strobe and returns a held snapshot
// of one register from a flattened bank. Optional macro: READBACK_PARITY_EN adds read_parity.
module register_readback #(
    parameter int NUM_REGS    = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    localparam int ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           read,
    input  logic [ADDR_WIDTH-1:0]          read_address,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] registers,
    output logic [DATA_WIDTH-1:0]          read_register,
    output logic                           read_valid,
    output logic                           busy,
    output logic                           address_error,
`ifdef READBACK_PARITY_EN
    output logic                           overrun,
    output logic                           read_parity
`else
    output logic                           overrun
`endif
);

    localparam int CNT_WIDTH = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        VALID,
        RELEASE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   read_s;
    logic                   read_prev;
    logic                   rise;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [CNT_WIDTH-1:0]   hold_cnt;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   sel_hit;

    assign read_s = sync_q[SYNC_STAGES-1];
    assign rise   = read_s & ~read_prev;
    assign busy   = (state != IDLE);

    // NOTE: read_prev starts at 1 and only tracks read_s once the synchroniser has filled with
    // real samples, so a strobe already high at reset release never looks like a new edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            fill_q    <= '0;
            read_prev <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], read};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            if (fill_q[SYNC_STAGES-1]) begin
                read_prev <= read_s;
            end
        end
    end

    // NOTE: both outputs get a default before the loop, so no latch is inferred and an
    // out-of-range address naturally selects zero.
    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == i[ADDR_WIDTH-1:0]) begin
                sel_data = registers[i*DATA_WIDTH +: DATA_WIDTH];
                sel_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rise) state_next = CAPTURE;
            CAPTURE: state_next = VALID;
            VALID:   if (hold_cnt == '0 && !read_s) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q        <= '0;
            hold_cnt      <= '0;
            read_register <= '0;
            read_valid    <= 1'b0;
            address_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (rise && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rise) begin
                        addr_q <= read_address;
                    end
                end
                CAPTURE: begin
                    read_register <= sel_data;
                    if (!sel_hit) begin
                        address_error <= 1'b1;
                    end
                    hold_cnt   <= HOLD_LOAD;
                    read_valid <= 1'b1;
                end
                VALID: begin
                    // Counter saturates at zero; valid drops on the same edge that enters RELEASE.
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if (!read_s) begin
                        read_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef READBACK_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_parity <= 1'b1;
        end else if (state == CAPTURE) begin
            read_parity <= ~^sel_data;
        end
    end
`endif

endmodule
